// File: rtl/turf_keys_pkg.sv
// Shared scan codes, key codes and frame states for the PS/2 key decoder.
// Scan code set 2 values; key codes match the directions stage case arms.
package turf_keys_pkg;

  localparam int TIMEOUT_CYCLES_DFLT = 50000;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_I     = 8'h43;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_KP8   = 8'h75;
  localparam logic [7:0] SC_KP5   = 8'h73;
  localparam logic [7:0] SC_KP4   = 8'h6B;
  localparam logic [7:0] SC_KP6   = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [4:0] KEY_P1_UP    = 5'd0;
  localparam logic [4:0] KEY_P1_DOWN  = 5'd1;
  localparam logic [4:0] KEY_P1_LEFT  = 5'd2;
  localparam logic [4:0] KEY_P1_RIGHT = 5'd3;
  localparam logic [4:0] KEY_P2_UP    = 5'd4;
  localparam logic [4:0] KEY_P2_DOWN  = 5'd5;
  localparam logic [4:0] KEY_P2_LEFT  = 5'd6;
  localparam logic [4:0] KEY_P2_RIGHT = 5'd7;
  localparam logic [4:0] KEY_P3_UP    = 5'd8;
  localparam logic [4:0] KEY_P3_DOWN  = 5'd9;
  localparam logic [4:0] KEY_P3_LEFT  = 5'd10;
  localparam logic [4:0] KEY_P3_RIGHT = 5'd11;
  localparam logic [4:0] KEY_P4_UP    = 5'd12;
  localparam logic [4:0] KEY_P4_DOWN  = 5'd13;
  localparam logic [4:0] KEY_P4_LEFT  = 5'd14;
  localparam logic [4:0] KEY_P4_RIGHT = 5'd15;
  localparam logic [4:0] KEY_RESET    = 5'd16;
  localparam logic [4:0] KEY_NONE     = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } ps2_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive framer: synchronisers, falling-edge detect, frame FSM, timeout.
// Delivers one good byte per strobe or a single-cycle error pulse.
module ps2_rx_frame
  import turf_keys_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_strobe_o,
  output logic       frame_err_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  clk_sync_q;
  logic [1:0]  dat_sync_q;
  ps2_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  byte_q, byte_d;
  logic        stb_q, stb_d;
  logic        err_q, err_d;
  logic        fall;
  logic        dat;

  // bit 2 holds the previous synced clock for edge detection
  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign dat  = dat_sync_q[1];

  // synchronisers and frame state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_q     <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
    end
  end

  // next-state: frame sequencing, timeout abort, strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    byte_d  = byte_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    tmo_d   = (fall || state_q == S_IDLE) ? 16'd0 : tmo_q + 16'd1;
    if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!dat) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d = {dat, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = ^{shift_q, dat};
          state_d = S_STOP;
        end
        S_STOP: begin
          if (dat && par_q) begin
            stb_d  = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rx_byte_o   = byte_q;
  assign rx_strobe_o = stb_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: make/break/E0 handling and held-key register.
// Feeds the directions stage with a 5-bit code, KEY_NONE when idle.
module ps2_key_decoder
  import turf_keys_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_valid,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [4:0] key_q, key_d;
  logic       kv_q, kv_d;
  logic [4:0] code;
  logic       hit;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk_i      (CLOCK_50),
    .rst_ni     (resetn),
    .ps2_clk_i  (PS2_CLK),
    .ps2_dat_i  (PS2_DAT),
    .rx_byte_o  (rx_byte),
    .rx_strobe_o(rx_strobe),
    .frame_err_o(frame_err)
  );

  // scan code to key code lookup, E0 selects arrow vs keypad
  always_comb begin
    hit  = 1'b1;
    code = KEY_NONE;
    case ({ext_q, rx_byte})
      {1'b0, SC_W}:     code = KEY_P1_UP;
      {1'b0, SC_S}:     code = KEY_P1_DOWN;
      {1'b0, SC_A}:     code = KEY_P1_LEFT;
      {1'b0, SC_D}:     code = KEY_P1_RIGHT;
      {1'b1, SC_UP}:    code = KEY_P2_UP;
      {1'b1, SC_DOWN}:  code = KEY_P2_DOWN;
      {1'b1, SC_LEFT}:  code = KEY_P2_LEFT;
      {1'b1, SC_RIGHT}: code = KEY_P2_RIGHT;
      {1'b0, SC_I}:     code = KEY_P3_UP;
      {1'b0, SC_K}:     code = KEY_P3_DOWN;
      {1'b0, SC_J}:     code = KEY_P3_LEFT;
      {1'b0, SC_L}:     code = KEY_P3_RIGHT;
      {1'b0, SC_KP8}:   code = KEY_P4_UP;
      {1'b0, SC_KP5}:   code = KEY_P4_DOWN;
      {1'b0, SC_KP4}:   code = KEY_P4_LEFT;
      {1'b0, SC_KP6}:   code = KEY_P4_RIGHT;
      {1'b0, SC_SPACE}: code = KEY_RESET;
      default:          hit  = 1'b0;
    endcase
  end

  // prefix flags and held-key register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      key_q <= KEY_NONE;
      kv_q  <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      key_q <= key_d;
      kv_q  <= kv_d;
    end
  end

  // byte decode: prefixes accumulate, any other byte consumes them
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    key_d = key_q;
    kv_d  = 1'b0;
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_strobe) begin
      unique case (1'b1)
        (rx_byte == SC_E0): ext_d = 1'b1;
        (rx_byte == SC_F0): brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (hit && !brk_q) begin
            key_d = code;
            kv_d  = 1'b1;
          end else if (hit && key_q == code) begin
            key_d = KEY_NONE;
          end
        end
      endcase
    end
  end

  assign KEY_PRESSED = key_q;
  assign key_valid   = kv_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a bit-banged PS/2 device.
// Device timing and timeout are scaled down to keep the run short.
module tb_ps2_key_decoder;
  import turf_keys_pkg::*;

  localparam int TMO = 1000;
  localparam int HP  = 40;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [4:0] KEY_PRESSED;
  logic       key_valid;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       frame_err;

  int n_chk = 0;
  int n_fail = 0;
  int kv_n = 0;
  int rx_n = 0;
  int fe_n = 0;
  int kv0, rx0, fe0;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .KEY_PRESSED(KEY_PRESSED),
    .key_valid  (key_valid),
    .rx_byte    (rx_byte),
    .rx_strobe  (rx_strobe),
    .frame_err  (frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // pulse counters
  always @(posedge CLOCK_50) begin
    if (key_valid) kv_n <= kv_n + 1;
    if (rx_strobe) rx_n <= rx_n + 1;
    if (frame_err) fe_n <= fe_n + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic bitx(input logic b);
    PS2_DAT = b;
    repeat (HP) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (HP) @(negedge CLOCK_50);
    PS2_CLK = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad);
    bitx(1'b0);
    for (int i = 0; i < 8; i++) bitx(b[i]);
    bitx((~^b) ^ bad);
    bitx(1'b1);
    PS2_DAT = 1'b1;
    repeat (2 * HP) @(negedge CLOCK_50);
  endtask

  task automatic mark();
    kv0 = kv_n;
    rx0 = rx_n;
    fe0 = fe_n;
  endtask

  initial begin
    int n;
    logic [7:0] b;
    repeat (5) @(negedge CLOCK_50);
    chk("rst_key", KEY_PRESSED, 31);
    chk("rst_kv", key_valid, 0);
    chk("rst_rxb", rx_byte, 0);
    chk("rst_stb", rx_strobe, 0);
    chk("rst_err", frame_err, 0);
    resetn = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    // 1: W make then break
    mark();
    send(8'h1D, 1'b0);
    chk("t1_make", KEY_PRESSED, 0);
    chk("t1_rxb", rx_byte, 8'h1D);
    send(8'hF0, 1'b0);
    send(8'h1D, 1'b0);
    chk("t1_brk", KEY_PRESSED, 31);
    chk("t1_kv", kv_n - kv0, 1);
    chk("t1_rx", rx_n - rx0, 3);
    chk("t1_err", fe_n - fe0, 0);

    // 2: arrow up vs keypad 8
    mark();
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    chk("t2_ext", KEY_PRESSED, 4);
    send(8'h75, 1'b0);
    chk("t2_kp", KEY_PRESSED, 12);
    chk("t2_kv", kv_n - kv0, 2);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    chk("t2_brk", KEY_PRESSED, 31);

    // 3: parity error then good byte
    mark();
    send(8'h1C, 1'b1);
    chk("t3_err", fe_n - fe0, 1);
    chk("t3_rx", rx_n - rx0, 0);
    chk("t3_key", KEY_PRESSED, 31);
    send(8'h23, 1'b0);
    chk("t3_good", KEY_PRESSED, 3);
    chk("t3_rxb", rx_byte, 8'h23);

    // 4: last pressed wins, break of other key ignored
    mark();
    send(8'h43, 1'b0);
    chk("t4_i", KEY_PRESSED, 8);
    send(8'h42, 1'b0);
    chk("t4_k", KEY_PRESSED, 9);
    send(8'h42, 1'b0);
    chk("t4_rep", KEY_PRESSED, 9);
    chk("t4_kv", kv_n - kv0, 3);
    send(8'hF0, 1'b0);
    send(8'h43, 1'b0);
    chk("t4_brk_i", KEY_PRESSED, 9);
    send(8'hF0, 1'b0);
    send(8'h42, 1'b0);
    chk("t4_brk_k", KEY_PRESSED, 31);

    // 5: timeout after start + 4 data bits
    mark();
    b = 8'h29;
    bitx(1'b0);
    for (int i = 0; i < 3; i++) bitx(b[i]);
    PS2_DAT = b[3];
    repeat (HP) @(negedge CLOCK_50);
    PS2_CLK = 1'b0;
    n = 0;
    while (n < 3 * TMO && !frame_err) begin
      @(negedge CLOCK_50);
      n++;
      if (n == HP) PS2_CLK = 1'b1;
    end
    chk("t5_tmo_win", int'(n >= TMO && n <= TMO + 6), 1);
    repeat (20) @(negedge CLOCK_50);
    chk("t5_err", fe_n - fe0, 1);
    chk("t5_key", KEY_PRESSED, 31);
    PS2_DAT = 1'b1;
    repeat (2 * HP) @(negedge CLOCK_50);
    send(8'h29, 1'b0);
    chk("t5_space", KEY_PRESSED, 16);

    // 6: reset mid-frame
    bitx(1'b0);
    bitx(1'b1);
    bitx(1'b1);
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("t6_key", KEY_PRESSED, 31);
    chk("t6_rxb", rx_byte, 0);
    chk("t6_kv", key_valid, 0);
    chk("t6_err", frame_err, 0);
    PS2_DAT = 1'b1;
    repeat (2 * HP) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    mark();
    send(8'h1B, 1'b0);
    chk("t6_s", KEY_PRESSED, 1);
    chk("t6_noerr", fe_n - fe0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
